// File: rtl/fixed_point_divider.sv
// fixed_point_divider: iterative signed Q(M.Q) divider, radix-2 restoring on magnitudes
module fixed_point_divider #(
  parameter int M = 7,
  parameter int Q = 8,
  parameter bit SATURATE = 1,
  localparam int W = M + Q + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quot,
  output logic         overflow,
  output logic         div_by_zero
);
  localparam int WQ = W + Q;
  localparam int CW = $clog2(WQ);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_n;
  logic [WQ-1:0] n, qacc;
  logic [W:0] d, rem, r2, abs_a, abs_b;
  logic [WQ:0] nx, lim;
  logic [CW-1:0] count;
  logic [W-1:0] max_p, qw, qf;
  logic sign, ge, ovf;
  // magnitudes in W+1 bits so the most negative operand stays exact
  assign abs_a = a[W-1] ? -{a[W-1], a} : {a[W-1], a};
  assign abs_b = b[W-1] ? -{b[W-1], b} : {b[W-1], b};
  assign nx = (WQ+1)'(abs_a) << Q;
  assign max_p = {1'b0, {(W-1){1'b1}}};
  assign r2 = {rem[W-1:0], n[WQ-1]};
  assign ge = r2 >= d;
  assign lim = (WQ+1)'(1) << (W-1);
  assign ovf = sign ? {1'b0, qacc} > lim : {1'b0, qacc} >= lim;
  assign qw = sign ? -qacc[W-1:0] : qacc[W-1:0];
  assign qf = (ovf && SATURATE) ? (sign ? ~max_p : max_p) : qw;
  assign in_ready = state == IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = in_valid ? (b == '0 ? DONE : CALC) : IDLE;
      CALC: state_n = count == CW'(WQ-1) ? FIX : CALC;
      FIX:  state_n = DONE;
      DONE: state_n = (out_valid && out_ready) ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      out_valid <= 1'b0;
      quot <= '0;
      overflow <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_n;
      out_valid <= state == DONE && !(out_valid && out_ready);
      if (state == IDLE && in_valid && b == '0) begin
        quot <= a[W-1] ? ~max_p : max_p;
        overflow <= 1'b0;
        div_by_zero <= 1'b1;
      end
      if (state == FIX) begin
        quot <= qf;
        overflow <= ovf;
        div_by_zero <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      n <= nx[WQ-1:0];
      d <= abs_b;
      rem <= '0;
      qacc <= '0;
      count <= '0;
      sign <= a[W-1] ^ b[W-1];
    end else if (state == CALC) begin
      n <= n << 1;
      rem <= ge ? r2 - d : r2;
      qacc <= {qacc[WQ-2:0], ge};
      count <= count + 1'b1;
    end
  end
endmodule

// File: tb/tb_fixed_point_divider.sv
// tb_fixed_point_divider: directed vectors against saturating and wrapping instances
module tb_fixed_point_divider;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic in_ready, out_valid, overflow, div_by_zero;
  logic in_ready_w, out_valid_w, overflow_w, div_by_zero_w;
  logic [15:0] quot, quot_w;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  fixed_point_divider #(.M(7), .Q(8), .SATURATE(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .quot(quot), .overflow(overflow),
    .div_by_zero(div_by_zero)
  );
  fixed_point_divider #(.M(7), .Q(8), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w), .a(a), .b(b),
    .out_valid(out_valid_w), .out_ready(out_ready), .quot(quot_w), .overflow(overflow_w),
    .div_by_zero(div_by_zero_w)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input logic [15:0] ta, input logic [15:0] tb2,
                     input logic [15:0] eq, input logic [15:0] ew, input logic eov,
                     input logic edz, input int elat, input int hold);
    int lat;
    logic stable;
    @(negedge clk);
    a = ta;
    b = tb2;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " quot"}, quot, eq);
    check({tag, " quot_wrap"}, quot_w, ew);
    check({tag, " overflow"}, {overflow, overflow_w}, {eov, eov});
    check({tag, " div_by_zero"}, {div_by_zero, div_by_zero_w}, {edz, edz});
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      a = 16'h0100;
      b = 16'h0100;
      in_valid = 1'b1;
      @(posedge clk);
      #1 if (quot !== eq || !out_valid || in_ready) stable = 1'b0;
    end
    if (hold > 0) check({tag, " held stable"}, stable, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, " consumed"}, {out_valid, out_valid_w}, 2'b00);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset state", {out_valid, overflow, div_by_zero, in_ready, quot}, {4'b0001, 16'h0000});
    run("3/2", 16'h0300, 16'h0200, 16'h0180, 16'h0180, 0, 0, 26, 0);
    run("-1/3", 16'hFF00, 16'h0300, 16'hFFAB, 16'hFFAB, 0, 0, 26, 0);
    run("max/0.5", 16'h7FFF, 16'h0080, 16'h7FFF, 16'hFFFE, 1, 0, 26, 0);
    run("min/-1", 16'h8000, 16'hFF00, 16'h7FFF, 16'h8000, 1, 0, 26, 0);
    run("min/1", 16'h8000, 16'h0100, 16'h8000, 16'h8000, 0, 0, 26, 0);
    run("neg/0", 16'hFE00, 16'h0000, 16'h8000, 16'h8000, 0, 1, 1, 0);
    run("pos/0", 16'h0100, 16'h0000, 16'h7FFF, 16'h7FFF, 0, 1, 1, 0);
    run("0/-1", 16'h0000, 16'hFF00, 16'h0000, 16'h0000, 0, 0, 26, 0);
    run("1/3 hold", 16'h0100, 16'h0300, 16'h0055, 16'h0055, 0, 0, 26, 10);
    @(negedge clk);
    a = 16'h0300;
    b = 16'h0200;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("abort state", {out_valid, in_ready}, 2'b01);
    repeat (30) @(posedge clk);
    #1 check("abort no output", out_valid, 1'b0);
    run("after abort", 16'hFD00, 16'h0200, 16'hFE80, 16'hFE80, 0, 0, 26, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
